// File: rtl/ftdi_tx_arbiter.sv
// rtl/ftdi_tx_arbiter.sv - round-robin, packet-locked arbiter sharing the FTDI write channel
// Optional header byte per packet: define FTDI_TX_HDR_EN.
module ftdi_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk_i,
    input  logic                   async_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   ftdi_wr_fifo_empty,
    output logic [7:0]             ftdi_wr_data,
    input  logic                   ftdi_wr_fifo_en,
    output logic                   grant_vld,
    output logic [IDX_W-1:0]       grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] last_idx_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_vld_q;
    logic             out_valid_q;
    logic [7:0]       data_q;

    logic             can_load;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             xfer;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // The output register may take a new byte when empty or being drained this cycle
    assign can_load = !out_valid_q || ftdi_wr_fifo_en;

    // Mux the current owner's stream signals
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == grant_idx_q) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_data  = req_data[8*k +: 8];
            end
        end
    end

    // Only the owner sees ready, and only while in BURST
    always_comb begin
        req_ready = '0;
        if (state_q == S_BURST) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req_ready[k] = (IDX_W'(k) == grant_idx_q) && can_load;
            end
        end
    end

    assign xfer = (state_q == S_BURST) && sel_valid && can_load;

    // Round-robin pick: first valid requester after the last one served
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_found && req_valid[(int'(last_idx_q) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(last_idx_q) + i) % NUM_REQ);
            end
        end
    end

`ifdef FTDI_TX_HDR_EN
    logic [7:0] hdr_byte;
    assign hdr_byte = {4'hA, 1'b0, 3'(grant_idx_q)};
`endif

    // Arbitration FSM plus the single output byte register
    always_ff @(posedge clk_i or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= S_IDLE;
            last_idx_q  <= IDX_W'(NUM_REQ - 1);
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            if (xfer) begin
                data_q      <= sel_data;
                out_valid_q <= 1'b1;
`ifdef FTDI_TX_HDR_EN
            end else if ((state_q == S_HDR) && can_load) begin
                data_q      <= hdr_byte;
                out_valid_q <= 1'b1;
`endif
            end else if (ftdi_wr_fifo_en && out_valid_q) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_idx_q <= pick_idx;
                        grant_vld_q <= 1'b1;
`ifdef FTDI_TX_HDR_EN
                        state_q     <= S_HDR;
`else
                        state_q     <= S_BURST;
`endif
                    end
                end
`ifdef FTDI_TX_HDR_EN
                S_HDR: begin
                    if (can_load) begin
                        state_q <= S_BURST;
                    end
                end
`endif
                S_BURST: begin
                    if (xfer && sel_last) begin
                        last_idx_q  <= grant_idx_q;
                        grant_vld_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ftdi_wr_fifo_empty = !out_valid_q;
    assign ftdi_wr_data       = data_q;
    assign grant_vld          = grant_vld_q;
    assign grant_idx          = grant_idx_q;

endmodule
